// File: rtl/prbs_pkg.sv
// Shared definitions for the 48-bit PRBS link: start word, injected-error mask,
// the 24-bit LFSR step and the receive checker state encoding.
package prbs_pkg;

  localparam logic [47:0] START_PATTERN = 48'hFFFFFF000000;
  localparam logic [47:0] ERR_INJ_MASK  = 48'h608000400100;

  typedef enum logic [1:0] {
    StHunt,
    StStart,
    StVerify,
    StLocked
  } prbs_state_e;

  // One step of the [24,23,22,17] Fibonacci LFSR.
  function automatic logic [23:0] lfsr24_step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

endpackage

// File: rtl/popcount48.sv
// Registered population count of a 48-bit word; one cycle of latency.
module popcount48 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [47:0] data_i,
  output logic [5:0]  count_o
);

  logic [5:0] count_d, count_q;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < 48; i++) begin
      count_d = count_d + {5'd0, data_i[i]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs_rx_checker.sv
// Receive-side PRBS checker: hunts the start word, locks to the LFSR sequence,
// counts bit errors and measures marker-to-first-word latency.
module prbs_rx_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_WORDS = 4,
  parameter int unsigned LOSS_WORDS = 4,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LAT_W      = 8
) (
  input  logic             GEN_CLK,
  input  logic             RST,
  input  logic             DATA_VALID,
  input  logic [47:0]      PRBS_IN,
  input  logic             STRT_LTNCY,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR_STRB,
  output logic [5:0]       ERR_BITS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic [LAT_W-1:0] LTNCY,
  output logic             LTNCY_VLD
);

  localparam int unsigned MatchW = $clog2(LOCK_WORDS + 1);
  localparam int unsigned LossW  = $clog2(LOSS_WORDS + 1);

  prbs_state_e       state_d, state_q;
  logic [MatchW-1:0] match_d, match_q;
  logic [LossW-1:0]  loss_d, loss_q;
  logic [23:0]       lprev_d, lprev_q;
  logic [23:0]       ref_d, ref_q;
  logic [47:0]       diff_d, diff_q;
  logic              vld0_d, vld0_q;
  logic              strb_d, strb_q;
  logic [CNT_W-1:0]  err_cnt_d, err_cnt_q;
  logic [CNT_W-1:0]  word_cnt_d, word_cnt_q;
  logic              strt_prev_q;
  logic              lat_run_d, lat_run_q;
  logic [LAT_W-1:0]  lat_cnt_d, lat_cnt_q;
  logic [LAT_W-1:0]  ltncy_d, ltncy_q;
  logic              ltncy_vld_d, ltncy_vld_q;

  logic [23:0]      word_h, word_l, ref_next;
  logic [47:0]      exp_word;
  logic             is_start, l_ok, h_ok, bad_word, loss_hit, strt_rise, lat_stop;
  logic [CNT_W:0]   err_sum;
  logic [LAT_W-1:0] lat_inc;

  assign word_h   = PRBS_IN[47:24];
  assign word_l   = PRBS_IN[23:0];
  assign is_start = (PRBS_IN == START_PATTERN);
  assign l_ok     = (word_l == lfsr24_step(word_h));
  assign h_ok     = (word_h == lfsr24_step(lprev_q));
  assign ref_next = lfsr24_step(ref_q);
  assign exp_word = {ref_q, ref_next};

  // Loss is judged on the delayed popcount; in-flight words are dropped when it hits.
  assign bad_word = (ERR_BITS > 6'(ERR_THRESH));
  assign loss_hit = (state_q == StLocked) && strb_q && bad_word &&
                    (loss_q == LossW'(LOSS_WORDS - 1));

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    loss_d  = loss_q;
    lprev_d = lprev_q;
    ref_d   = ref_q;
    diff_d  = diff_q;
    vld0_d  = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (DATA_VALID && is_start) state_d = StStart;
      end
      StStart: begin
        if (DATA_VALID && !is_start) begin
          if (l_ok) begin
            state_d = StVerify;
            match_d = MatchW'(1);
            lprev_d = word_l;
          end else begin
            state_d = StHunt;
          end
        end
      end
      StVerify: begin
        if (DATA_VALID) begin
          if (l_ok && h_ok) begin
            if (match_q == MatchW'(LOCK_WORDS - 1)) begin
              state_d = StLocked;
              ref_d   = lfsr24_step(word_l);
              loss_d  = '0;
            end else begin
              match_d = match_q + MatchW'(1);
              lprev_d = word_l;
            end
          end else begin
            state_d = StHunt;
          end
        end
      end
      StLocked: begin
        if (strb_q) loss_d = bad_word ? loss_q + LossW'(1) : '0;
        if (DATA_VALID) begin
          vld0_d = 1'b1;
          diff_d = PRBS_IN ^ exp_word;
          // Reference free-runs so a corrupted word never propagates.
          ref_d  = lfsr24_step(ref_next);
          if (is_start) state_d = StStart;
        end
        if (loss_hit) begin
          vld0_d = 1'b0;
          if (!(DATA_VALID && is_start)) state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  assign strb_d  = vld0_q && !loss_hit;
  assign err_sum = {1'b0, err_cnt_q} + {{(CNT_W - 5){1'b0}}, ERR_BITS};

  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (CLR_CNT) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (strb_q) begin
      err_cnt_d  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CNT_W'(1);
    end
  end

  assign strt_rise = STRT_LTNCY && !strt_prev_q;
  assign lat_stop  = lat_run_q && (state_q == StStart) && DATA_VALID && !is_start;
  assign lat_inc   = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

  always_comb begin
    lat_run_d   = lat_run_q;
    lat_cnt_d   = lat_cnt_q;
    ltncy_d     = ltncy_q;
    ltncy_vld_d = ltncy_vld_q;
    if (strt_rise) begin
      lat_run_d   = 1'b1;
      lat_cnt_d   = '0;
      ltncy_vld_d = 1'b0;
    end else if (lat_stop) begin
      lat_run_d   = 1'b0;
      ltncy_d     = lat_inc;
      ltncy_vld_d = 1'b1;
    end else if (lat_run_q) begin
      lat_cnt_d = lat_inc;
    end
  end

  always_ff @(posedge GEN_CLK) begin
    if (RST) begin
      state_q     <= StHunt;
      match_q     <= '0;
      loss_q      <= '0;
      lprev_q     <= '0;
      ref_q       <= '0;
      diff_q      <= '0;
      vld0_q      <= 1'b0;
      strb_q      <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      strt_prev_q <= 1'b0;
      lat_run_q   <= 1'b0;
      lat_cnt_q   <= '0;
      ltncy_q     <= '0;
      ltncy_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      lprev_q     <= lprev_d;
      ref_q       <= ref_d;
      diff_q      <= diff_d;
      vld0_q      <= vld0_d;
      strb_q      <= strb_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      strt_prev_q <= STRT_LTNCY;
      lat_run_q   <= lat_run_d;
      lat_cnt_q   <= lat_cnt_d;
      ltncy_q     <= ltncy_d;
      ltncy_vld_q <= ltncy_vld_d;
    end
  end

  popcount48 u_popcount (
    .clk_i   (GEN_CLK),
    .rst_i   (RST),
    .data_i  (diff_q),
    .count_o (ERR_BITS)
  );

  assign LOCKED    = (state_q == StLocked);
  assign ERR_STRB  = strb_q;
  assign ERR_CNT   = err_cnt_q;
  assign WORD_CNT  = word_cnt_q;
  assign LTNCY     = ltncy_q;
  assign LTNCY_VLD = ltncy_vld_q;

endmodule
